wave_ram_reader: RTL and testbench

//  Read-side sequencer for the capture RAM (simple dual-port, rd_clk domain, no read enable).
//  On a start pulse, reads `length` samples from a circular buffer beginning at start_addr
//  (addresses wrap mod 2^ADDR_WIDTH) and streams them out on a valid/ready interface with

---
 rtl/wave_ram_reader_pkg.sv | 28 ++
 rtl/wave_ram_reader_if.sv | 12 +
 rtl/wave_ram_reader_skid_fifo.sv | 56 +++++
 rtl/wave_ram_reader.sv | 131 +++++++++++++
 tb/tb_wave_ram_reader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wave_ram_reader_pkg.sv
// Shared definitions for the capture-RAM read sequencer: FSM encoding,
// capture RAM geometry and parameter legality checks.
package wave_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } wave_rd_state_e;

  // Geometry of the capture RAM this reader is paired with
  localparam int CAP_ADDR_WIDTH = 10;
  localparam int CAP_DATA_WIDTH = 8;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 2;
  localparam int ADDR_WIDTH_MIN = 1;
  localparam int ADDR_WIDTH_MAX = 20;

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

  function automatic bit addr_width_ok(input int aw);
    return (aw >= ADDR_WIDTH_MIN) && (aw <= ADDR_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/wave_ram_reader_if.sv
// Output sample stream of the capture-RAM reader (valid/ready with last-beat marking).
interface wave_ram_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/wave_ram_reader_skid_fifo.sv
// Shift-register FIFO whose head entry is a register, so the stream outputs
// are glitch-free and hold while the sink stalls.
module wave_rd_skid_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 9,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNTW-1:0]  count
);

  logic [WIDTH-1:0] mem_q   [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [CNTW-1:0]  cnt_nxt;
  logic [CNTW-1:0]  wr_idx;
  logic             do_pop;

  always_comb begin
    do_pop  = pop & head_valid;
    wr_idx  = count - CNTW'(do_pop);
    cnt_nxt = count + CNTW'(push) - CNTW'(do_pop);
    for (int i = 0; i < DEPTH; i++) mem_nxt[i] = mem_q[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (do_pop) mem_nxt[i] = mem_q[i + 1];
    end
    // A push lands behind the last surviving entry, which also covers push+pop when full
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CNTW'(i))) mem_nxt[i] = push_data;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      count      <= '0;
      head_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      count      <= cnt_nxt;
      head_valid <= (cnt_nxt != '0);
      mem_q      <= mem_nxt;
    end
  end

  assign head_data = mem_q[0];

endmodule

// File: rtl/wave_ram_reader.sv
// Read-side sequencer for the capture RAM: walks a circular address range and
// streams the samples out, absorbing RAM read latency under back-pressure.
module wave_ram_reader
  import wave_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = CAP_ADDR_WIDTH,
  parameter int DATA_WIDTH = CAP_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  wave_ram_reader_if.master     m,
  output logic                  busy,
  output logic                  done
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int IFW   = $clog2(RD_LATENCY + 1);
  localparam int CW    = 8;
  localparam logic [ADDR_WIDTH:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] REM_ONE  = 1;

  if (!rd_latency_ok(RD_LATENCY) || !addr_width_ok(ADDR_WIDTH)) begin : g_param_check
    $error("wave_ram_reader: RD_LATENCY or ADDR_WIDTH out of range");
  end

  function automatic logic [ADDR_WIDTH:0] clamp_len(input logic [ADDR_WIDTH:0] len);
    return (len > FULL_LEN) ? FULL_LEN : len;
  endfunction

  wave_rd_state_e          state;
  logic [ADDR_WIDTH:0]     rem;
  logic [RD_LATENCY-1:0]   vld_p;
  logic [RD_LATENCY-1:0]   lst_p;
  logic [CNTW-1:0]         fifo_cnt;
  logic [IFW-1:0]          inflight;
  logic signed [CW-1:0]    credit;
  logic                    pop;
  logic                    issue;
  logic                    push;
  logic                    head_valid;
  logic [DATA_WIDTH:0]     head;

  // Credit reserves a FIFO slot for every read still inside the RAM pipe
  always_comb begin
    pop      = head_valid & m.m_ready;
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + IFW'(vld_p[i]);
    credit = $signed(CW'(DEPTH)) - $signed(CW'(fifo_cnt)) - $signed(CW'(inflight))
           + $signed(CW'(pop));
    issue  = (state == READ) && !abort && (credit > 8'sd0);
    push   = vld_p[RD_LATENCY-1];
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state       <= IDLE;
      ram_rd_addr <= '0;
      rem         <= '0;
      vld_p       <= '0;
      lst_p       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done  <= 1'b0;
      // Stage boundary: address issue -> RAM read pipe
      vld_p <= (vld_p << 1) | RD_LATENCY'(issue);
      lst_p <= (lst_p << 1) | RD_LATENCY'(issue && (rem == REM_ONE));
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        vld_p <= '0;
        lst_p <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (length != '0)) begin
              state       <= READ;
              busy        <= 1'b1;
              ram_rd_addr <= start_addr;
              rem         <= clamp_len(length);
            end
          end
          READ: begin
            if (issue) begin
              rem <= rem - REM_ONE;
              if (rem == REM_ONE) state <= DRAIN;
              else ram_rd_addr <= ram_rd_addr + ADDR_WIDTH'(1);
            end
          end
          DRAIN: begin
            if (pop && m.m_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Stage boundary: RAM read data -> output FIFO
  wave_rd_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .flush      (abort),
    .push       (push),
    .push_data  ({lst_p[RD_LATENCY-1], ram_rd_data}),
    .pop        (pop),
    .head_data  (head),
    .head_valid (head_valid),
    .count      (fifo_cnt)
  );

  assign m.m_valid = head_valid;
  assign m.m_data  = head[DATA_WIDTH-1:0];
  assign m.m_last  = head[DATA_WIDTH];

endmodule

// File: tb/tb_wave_ram_reader.sv
// Bench for wave_ram_reader: two instances (RD_LATENCY 1 and 2) share one
// stimulus stream; a per-cycle monitor records beats and checks handshake rules.
module tb_wave_ram_reader;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b1;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;

  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] mdat  [2];
  logic          mval  [2];
  logic          mlst  [2];
  logic          bsy   [2];
  logic          dn    [2];

  wave_ram_reader_if #(.DATA_WIDTH(DW)) ifc0 ();
  wave_ram_reader_if #(.DATA_WIDTH(DW)) ifc1 ();
  assign ifc0.m_ready = m_ready;
  assign ifc1.m_ready = m_ready;
  assign mdat[0] = ifc0.m_data;
  assign mval[0] = ifc0.m_valid;
  assign mlst[0] = ifc0.m_last;
  assign mdat[1] = ifc1.m_data;
  assign mval[1] = ifc1.m_valid;
  assign mlst[1] = ifc1.m_last;

  wave_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut0 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .ram_rd_addr(raddr[0]), .ram_rd_data(rdata[0]),
    .m(ifc0.master), .busy(bsy[0]), .done(dn[0]));

  wave_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .ram_rd_addr(raddr[1]), .ram_rd_data(rdata[1]),
    .m(ifc1.master), .busy(bsy[1]), .done(dn[1]));

  always #5 rd_clk = ~rd_clk;

  // Capture RAM model: mem[a] = a[7:0], one or two register stages
  logic [DW-1:0] r0_q1, r1_q1, r1_q2;
  always @(posedge rd_clk) begin
    r0_q1 <= raddr[0][7:0];
    r1_q1 <= raddr[1][7:0];
    r1_q2 <= r1_q1;
  end
  assign rdata[0] = r0_q1;
  assign rdata[1] = r1_q2;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW:0]   len;
    int            mode;      // 0 ready high, 1 random, 2 low for `stall` cycles
    int            stall;
    bit            lat;
    int            exp_n;
    logic [7:0]    exp_first;
    logic [7:0]    exp_lastd;
  } vec_t;

  vec_t vecs [7];

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [8:0] beats [2][0:2047];
  int         nbeats [2];
  int         first_cyc [2];
  int         done_cnt [2];
  bit         pend_done [2];
  bit         stall_prev [2];
  logic [8:0] prev_beat [2];
  bit         abort_prev = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[lat%0d]: got 0x%0h, required 0x%0h", nm, k + 1, act, exp);
    end
  endtask

  task automatic mon_sample();
    for (int k = 0; k < 2; k++) begin
      if (rd_rst) begin
        pend_done[k]  = 1'b0;
        stall_prev[k] = 1'b0;
        continue;
      end
      if (stall_prev[k] && !abort_prev)
        chk("hold_while_stalled", k, {mval[k], mlst[k], mdat[k]}, {1'b1, prev_beat[k]});
      if (dn[k] || pend_done[k]) begin
        chk("done_pulse", k, dn[k], pend_done[k]);
        if (pend_done[k]) chk("busy_with_done", k, bsy[k], 0);
      end
      if (dn[k]) done_cnt[k]++;
      if (mval[k] && first_cyc[k] < 0) first_cyc[k] = cyc;
      pend_done[k] = 1'b0;
      if (mval[k] && m_ready) begin
        if (nbeats[k] < 2048) beats[k][nbeats[k]] = {mlst[k], mdat[k]};
        nbeats[k]++;
        pend_done[k] = mlst[k] && !abort;
      end
      stall_prev[k] = mval[k] && !m_ready;
      prev_beat[k]  = {mlst[k], mdat[k]};
    end
    abort_prev = abort;
  endtask

  task automatic tick();
    @(negedge rd_clk);
    mon_sample();
    @(posedge rd_clk);
    cyc++;
    #1;
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      nbeats[k]    = 0;
      first_cyc[k] = -1;
      done_cnt[k]  = 0;
    end
  endtask

  task automatic check_xfer(input vec_t v);
    logic [AW-1:0] a;
    logic [AW-1:0] a_end;
    int            errs;
    for (int k = 0; k < 2; k++) begin
      chk("beat_count", k, nbeats[k], v.exp_n);
      errs = 0;
      for (int i = 0; i < nbeats[k] && i < 2048; i++) begin
        a = v.sa + AW'(i);
        if (beats[k][i] !== {(i == v.exp_n - 1), a[7:0]}) errs++;
      end
      chk("beat_sequence_errors", k, errs, 0);
      if (nbeats[k] > 0 && nbeats[k] <= 2048) begin
        chk("first_beat", k, beats[k][0], {(v.exp_n == 1), v.exp_first});
        chk("last_beat", k, beats[k][nbeats[k] - 1], {1'b1, v.exp_lastd});
      end
      a_end = v.sa + AW'(v.exp_n - 1);
      chk("ram_rd_addr_hold", k, raddr[k], a_end);
      chk("busy_after", k, bsy[k], 0);
    end
  endtask

  task automatic run_xfer(input vec_t v, input int restart_at);
    int            e0;
    int            to;
    logic [AW-1:0] d;
    clear_mon();
    start_addr = v.sa;
    length     = v.len;
    start      = 1'b1;
    m_ready    = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    start = 1'b0;
    e0    = cyc;
    for (int k = 0; k < 2; k++) chk("addr_at_start", k, raddr[k], v.sa);
    to = 0;
    while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && to < 6000) begin
      if (v.mode == 2 && cyc - e0 == v.stall) begin
        for (int k = 0; k < 2; k++) begin
          d = raddr[k] - v.sa;
          n_cmp++;
          if (int'(d) > k + 2) begin
            n_fail++;
            $display("FAIL stall_issue[lat%0d]: %0d addresses issued, at most %0d allowed", k + 1, d, k + 2);
          end
          chk("stall_no_beats", k, nbeats[k], 0);
        end
        m_ready = 1'b1;
      end
      if (v.mode == 1) m_ready = 1'($urandom_range(0, 1));
      if (cyc - e0 == restart_at) begin
        start      = 1'b1;
        start_addr = 10'h300;
        length     = 11'd4;
      end else begin
        start = 1'b0;
      end
      tick();
      to++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    n_cmp++;
    if (to >= 6000) begin
      n_fail++;
      $display("FAIL xfer_timeout: done not seen within 6000 cycles (sa 0x%0h)", v.sa);
    end
    if (v.lat)
      for (int k = 0; k < 2; k++) chk("first_valid_latency", k, first_cyc[k] - e0, k + 2);
    check_xfer(v);
  endtask

  task automatic chk_reset_outputs();
    for (int k = 0; k < 2; k++) begin
      chk("rst_ram_rd_addr", k, raddr[k], 0);
      chk("rst_m_data", k, mdat[k], 0);
      chk("rst_m_valid", k, mval[k], 0);
      chk("rst_m_last", k, mlst[k], 0);
      chk("rst_busy", k, bsy[k], 0);
      chk("rst_done", k, dn[k], 0);
    end
  endtask

  initial begin
    int to;
    vecs[0] = '{10'h010, 11'd4,    0, 0,  1'b1, 4,    8'h10, 8'h13};
    vecs[1] = '{10'h3FE, 11'd4,    0, 0,  1'b1, 4,    8'hFE, 8'h01};
    vecs[2] = '{10'h155, 11'd1024, 1, 0,  1'b0, 1024, 8'h55, 8'h54};
    vecs[3] = '{10'h0F0, 11'd8,    2, 20, 1'b0, 8,    8'hF0, 8'hF7};
    vecs[4] = '{10'h2AA, 11'd1,    0, 0,  1'b1, 1,    8'hAA, 8'hAA};
    vecs[5] = '{10'h200, 11'd1025, 0, 0,  1'b0, 1024, 8'h00, 8'hFF};
    vecs[6] = '{10'h3FF, 11'd1024, 0, 0,  1'b0, 1024, 8'hFF, 8'hFE};
    clear_mon();

    #1;
    chk_reset_outputs();
    repeat (3) tick();
    rd_rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_xfer(vecs[i], -1);

    // Second start while busy must be ignored
    run_xfer('{10'h080, 11'd8, 0, 0, 1'b0, 8, 8'h80, 8'h87}, 2);

    // Zero-length start: no busy, no done, no beats
    clear_mon();
    start_addr = 10'h123;
    length     = '0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    for (int k = 0; k < 2; k++) begin
      chk("len0_busy", k, bsy[k], 0);
      chk("len0_beats", k, nbeats[k], 0);
      chk("len0_done", k, done_cnt[k], 0);
    end

    // Abort around the third beat, then restart on the very next cycle
    clear_mon();
    start_addr = 10'h100;
    length     = 11'd16;
    start      = 1'b1;
    tick();
    start = 1'b0;
    to = 0;
    while (nbeats[1] < 2 && to < 100) begin
      tick();
      to++;
    end
    chk("abort_reached_beat3", 1, nbeats[1], 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("abort_m_valid", k, mval[k], 0);
      chk("abort_busy", k, bsy[k], 0);
      chk("abort_done", k, done_cnt[k], 0);
      chk("abort_partial", k, nbeats[k] < 16, 1);
    end
    run_xfer('{10'h020, 11'd2, 0, 0, 1'b0, 2, 8'h20, 8'h21}, -1);

    // Asynchronous reset in the middle of a transfer
    clear_mon();
    start_addr = 10'h040;
    length     = 11'd32;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rd_rst = 1'b1;
    #1;
    chk_reset_outputs();
    repeat (2) tick();
    rd_rst = 1'b0;
    tick();
    run_xfer('{10'h3F0, 11'd3, 0, 0, 1'b1, 3, 8'hF0, 8'hF2}, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
